// File: rtl/tx_fsrc_place_pkg.sv
// Shared types and helpers for the TX FSRC sample placement block.
package tx_fsrc_place_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_NUM_SAMPLES  = 8;
    localparam int MAX_LANES        = 64;

    typedef logic [DEF_SAMPLE_WIDTH-1:0]              sample_t;
    typedef logic [$clog2(2*DEF_NUM_SAMPLES+1)-1:0]   cnt_t;

    // Number of set bits in a lane mask (masks narrower than MAX_LANES are zero-extended).
    function automatic int popcount(input logic [MAX_LANES-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_fsrc_sample_place_if.sv
// Stream/mask/output bundle of the TX FSRC sample placement block.
// slave = the placement block, master = its environment.
interface tx_fsrc_sample_place_if
    import tx_fsrc_place_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES
);
    logic                                    sync;
    logic [NUM_SAMPLES-1:0][SAMPLE_WIDTH-1:0] in_data;
    logic                                    in_valid;
    logic                                    in_ready;
    logic [NUM_SAMPLES-1:0]                  sample_en;
    logic                                    sample_en_valid;
    logic [NUM_SAMPLES-1:0][SAMPLE_WIDTH-1:0] out_data;
    logic [NUM_SAMPLES-1:0]                  out_en;
    logic                                    out_valid;
    logic                                    underflow;

    modport master (
        output sync, in_data, in_valid, sample_en, sample_en_valid,
        input  in_ready, out_data, out_en, out_valid, underflow
    );

    modport slave (
        input  sync, in_data, in_valid, sample_en, sample_en_valid,
        output in_ready, out_data, out_en, out_valid, underflow
    );
endinterface

// File: rtl/tx_fsrc_prefix_cnt.sv
// Exclusive prefix popcount of the lane enable mask: prefix[i] is the number of
// enabled lanes below lane i, i.e. the buffer index lane i reads when enabled.
module tx_fsrc_prefix_cnt
    import tx_fsrc_place_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int KW          = $clog2(NUM_SAMPLES + 1)
)(
    input  logic [NUM_SAMPLES-1:0]         sample_en,
    output logic [NUM_SAMPLES-1:0][KW-1:0] prefix,
    output logic [KW-1:0]                  k
);

    logic [KW-1:0] acc;

    // Running sum over lanes plus the total number of enabled lanes.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            prefix[i] = acc;
            acc       = acc + KW'(sample_en[i]);
        end
        k = KW'(popcount(MAX_LANES'(sample_en)));
    end

endmodule

// File: rtl/tx_fsrc_sample_place.sv
// TX FSRC sample placement: places buffered input samples, in order, onto the
// output lanes flagged by the accumulator enable mask; disabled lanes repeat the
// previous placed sample. Define TX_FSRC_ZERO_FILL_EN to output 0 on disabled
// lanes instead.
module tx_fsrc_sample_place
    import tx_fsrc_place_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES
)(
    input  logic                  clk,
    input  logic                  reset,
    tx_fsrc_sample_place_if.slave bus
);

    localparam int N  = NUM_SAMPLES;
    localparam int B  = 2 * N;
    localparam int CW = $clog2(B + 1);
    localparam int KW = $clog2(N + 1);

    typedef logic [SAMPLE_WIDTH-1:0] lane_t;

    lane_t                          sbuf_q [B];
    lane_t                          sbuf_d [B];
    lane_t                          src_ext [B+N];
    logic [CW-1:0]                  cnt_q, cnt_d;
    lane_t                          hold_q, hold_d;
    logic [N-1:0][SAMPLE_WIDTH-1:0] out_data_q, out_data_d;
    logic [N-1:0][SAMPLE_WIDTH-1:0] lane_val;
    lane_t                          prev;
    logic [N-1:0]                   out_en_q, out_en_d;
    logic                           out_valid_q, out_valid_d;
    logic                           underflow_q, underflow_d;

    logic [N-1:0][KW-1:0]           prefix;
    logic [KW-1:0]                  k;
    logic [CW-1:0]                  k_ext, shift, base;
    logic                           in_ready, accept, starved, service;

    tx_fsrc_prefix_cnt #(
        .NUM_SAMPLES (N),
        .KW          (KW)
    ) u_prefix (
        .sample_en (bus.sample_en),
        .prefix    (prefix),
        .k         (k)
    );

    // Handshake and service decisions, all from the registered count; sync overrides.
    always_comb begin
        in_ready = (cnt_q <= CW'(N));
        k_ext    = CW'(k);
        starved  = (cnt_q < k_ext);
        accept   = bus.in_valid && in_ready && !bus.sync;
        service  = bus.sample_en_valid && !starved && !bus.sync;
    end

    // Lane placement: enabled lanes read the buffer in order, disabled lanes fill.
    always_comb begin
        lane_val = '0;
        prev     = hold_q;
        for (int i = 0; i < N; i++) begin
            if (bus.sample_en[i]) begin
                for (int p = 0; p < N; p++) begin
                    if (prefix[i] == KW'(p)) begin
                        lane_val[i] = sbuf_q[p];
                    end
                end
            end else begin
`ifdef TX_FSRC_ZERO_FILL_EN
                lane_val[i] = '0;
`else
                lane_val[i] = prev;
`endif
            end
            prev = lane_val[i];
        end
    end

    // Buffer shift by consumed count, append of accepted word, and output staging.
    always_comb begin
        shift = service ? k_ext : '0;
        base  = cnt_q - shift;

        for (int j = 0; j < B; j++) begin
            src_ext[j] = sbuf_q[j];
        end
        for (int j = 0; j < N; j++) begin
            src_ext[B+j] = '0;
        end

        for (int j = 0; j < B; j++) begin
            sbuf_d[j] = sbuf_q[j];
            for (int s = 0; s <= N; s++) begin
                if (shift == CW'(s)) begin
                    sbuf_d[j] = src_ext[j+s];
                end
            end
        end

        // An accepted word lands right after the samples that survive this cycle.
        if (accept) begin
            for (int p = 0; p <= N; p++) begin
                if (base == CW'(p)) begin
                    for (int l = 0; l < N; l++) begin
                        sbuf_d[p+l] = bus.in_data[l];
                    end
                end
            end
        end

        cnt_d       = base + (accept ? CW'(N) : CW'(0));
        hold_d      = service ? lane_val[N-1] : hold_q;
        out_data_d  = service ? lane_val : out_data_q;
        out_en_d    = service ? bus.sample_en : out_en_q;
        out_valid_d = service;
        underflow_d = bus.sample_en_valid && starved && !bus.sync;

        if (bus.sync) begin
            cnt_d       = '0;
            hold_d      = '0;
            out_valid_d = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // State registers; reset clears everything so no partial word survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < B; j++) begin
                sbuf_q[j] <= '0;
            end
            cnt_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_en_q    <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int j = 0; j < B; j++) begin
                sbuf_q[j] <= sbuf_d[j];
            end
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_en_q    <= out_en_d;
            out_valid_q <= out_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_en    = out_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.underflow = underflow_q;

endmodule
